// File: rtl/lsu_align.sv
// lsu_align: load/store alignment between EXECUTE and a word-wide bus.
// Ports: req_* (request in, req_ready out), resp_* / misalign_err (completion),
// mem_* (word bus). Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_align #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rbusy,
  input  logic                  mem_wbusy
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_WAIT,
    WR_STROBE,
    MIS_RESP
  } state_t;

  state_t state, state_d;

  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic                  resp_valid_d;
  logic [31:0]           resp_rdata_d;
  logic                  err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mem_rstrb_d;
  logic [3:0]            mem_wmask_d;
  logic [31:0]           mem_wdata_d;
  logic                  accept;

  function automatic logic [3:0] st_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (size == 2'b00): m = 4'b0001 << off;
      (size == 2'b01): m = off[1] ? 4'b1100 : 4'b0011;
      (size == 2'b10): m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] st_data(
    input logic [1:0]  size,
    input logic [31:0] wd
  );
    logic [31:0] d;
    d = wd;
    unique case (1'b1)
      (size == 2'b00): d = {4{wd[7:0]}};
      (size == 2'b01): d = {2{wd[15:0]}};
      default:         d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] rd
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    r = rd;
    // funct3[2] selects zero-extension; size 11 falls through to word
    unique case (1'b1)
      (f3[1:0] == 2'b00): r = {{24{b[7] & ~f3[2]}}, b};
      (f3[1:0] == 2'b01): r = {{16{h[15] & ~f3[2]}}, h};
      default:            r = rd;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == 2'b01) && off[0]) ||
           ((size == 2'b10) && (off != 2'b00));
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state;
    off_d        = off_q;
    f3_d         = f3_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    err_d        = misalign_err;
    mem_addr_d   = mem_addr;
    mem_rstrb_d  = 1'b0;
    mem_wmask_d  = mem_wmask;
    mem_wdata_d  = mem_wdata;
    unique case (state)
      IDLE: begin
        if (accept) begin
          mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          off_d      = req_addr[1:0];
          f3_d       = req_funct3;
          if (TRAP && misaligned(req_funct3[1:0], req_addr[1:0])) begin
            state_d = MIS_RESP;
          end else if (req_is_store) begin
            state_d     = WR_STROBE;
            mem_wmask_d = st_mask(req_funct3[1:0], req_addr[1:0]);
            mem_wdata_d = st_data(req_funct3[1:0], req_wdata);
          end else begin
            state_d     = RD_STROBE;
            mem_rstrb_d = 1'b1;
          end
        end
      end
      RD_STROBE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (!mem_rbusy) begin
          resp_rdata_d = ld_ext(f3_q, off_q, mem_rdata);
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          state_d      = IDLE;
        end
      end
      WR_STROBE: begin
        if (!mem_wbusy) begin
          mem_wmask_d  = 4'b0000;
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          state_d      = IDLE;
        end
      end
      MIS_RESP: begin
        resp_rdata_d = 32'h0;
        resp_valid_d = 1'b1;
        err_d        = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      misalign_err <= 1'b0;
      mem_addr     <= '0;
      mem_rstrb    <= 1'b0;
      mem_wmask    <= 4'b0000;
      mem_wdata    <= 32'h0;
    end else begin
      state        <= state_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      misalign_err <= err_d;
      mem_addr     <= mem_addr_d;
      mem_rstrb    <= mem_rstrb_d;
      mem_wmask    <= mem_wmask_d;
      mem_wdata    <= mem_wdata_d;
    end
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the multi-cycle RISC-V core's EXECUTE stage and the word-wide memory/peripheral bus.
- Accepts one byte, half or word access per request and drives a word-aligned memory request with byte write mask and replicated write data.
- On loads, waits for read data, then extracts, sign- or zero-extends, and returns the value for register write-back.

Parameters:
ADDR_WIDTH, 32, width of req_addr and mem_addr.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  access request; accepted on a rising edge with req_valid && req_ready
req_ready  out  1  high exactly when FSM is IDLE (combinational from state)
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the load/store instruction
req_addr  in  ADDR_WIDTH  byte address (rs1 + imm)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; held until the next load completes
misalign_err  out  1  valid with resp_valid (see Optional Feature)
mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] always 0
mem_rstrb  out  1  read strobe
mem_wmask  out  4  byte write enables, bit i = byte lane i
mem_wdata  out  32  lane-replicated write data
mem_rdata  in  32  read data, valid in RD_WAIT when mem_rbusy = 0
mem_rbusy  in  1  read not yet complete
mem_wbusy  in  1  write not yet accepted

Behaviour:
- Clock and reset: one clock `clk`. Reset `resetn` is asynchronous and active-low.
- Reset values: state IDLE; all registered outputs 0 (resp_valid, resp_rdata, misalign_err, mem_addr, mem_rstrb, mem_wmask, mem_wdata). req_ready = 1.
- Accept (edge T): latch addr, funct3, is_store and wdata.
  - mem_addr <= {addr[hi:2], 2'b00}.
  - Load: next state RD_STROBE.
  - Store: next state WR_STROBE.
- RD_STROBE: mem_rstrb = 1 for exactly this cycle; then go to RD_WAIT.
- RD_WAIT:
  - Stay while mem_rbusy = 1.
  - When mem_rbusy = 0: capture the extracted mem_rdata into resp_rdata, pulse resp_valid, go to IDLE.
  - With zero-busy memory, resp_valid is high in the cycle after edge T+2.
- WR_STROBE: mem_wmask and mem_wdata driven.
  - Hold them while mem_wbusy = 1.
  - On the edge where mem_wbusy = 0: clear wmask, pulse resp_valid (resp_rdata unchanged), go to IDLE.
  - With zero-busy memory, resp_valid is high after edge T+1.
- Back-to-back: the resp_valid cycle is an IDLE cycle, so a new request may be accepted in it.
- req_valid while req_ready = 0 is ignored; the requester re-presents it.
- Store lanes, with off = addr[1:0]:
  - SB (x00): wmask = 0001 << off; wdata = {4{wd[7:0]}}.
  - SH (x01): wmask = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - SW (x10): wmask = 1111; wdata = wd.
  - funct3[1:0] = 11: wmask = 0000; the access still completes normally.
- Loads:
  - LB (000) and LBU (100): byte at lane off, sign- or zero-extended.
  - LH (001) and LHU (101): half selected by addr[1], sign- or zero-extended.
  - LW (010): full word.
  - 011, 110, 111: treated as LW.
- Misaligned access without the macro: low address bits beyond the access size are ignored (LH at addr 0x11 reads the low half of word 0x10).
- Reset mid-operation: FSM goes to IDLE immediately and strobes/mask drop asynchronously. No resp_valid is generated for the aborted access.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, never touches memory.
  - No mem_rstrb; mem_wmask stays 0000.
  - resp_valid pulses after edge T+1 with misalign_err = 1 and resp_rdata = 0.
  - Aligned accesses complete with misalign_err = 0.
- Undefined: misalign_err is constant 0 and misaligned accesses behave as described in Behaviour.

Test Plan:
1. Release reset, LW addr 0x10, mem_rdata 0x8070F0A5, rbusy = 0 -> mem_addr 0x10; mem_rstrb high one cycle; resp_valid after edge T+2 with resp_rdata 0x8070F0A5; req_ready low in between.
2. Same memory word, each load issued separately:
   - LB 0x13 -> 0xFFFFFF80
   - LBU 0x11 -> 0x000000F0
   - LH 0x12 -> 0xFFFF8070
   - LHU 0x10 -> 0x0000F0A5
3. Stores:
   - SB 0x22, wdata 0x123456AB -> mem_addr 0x20, wmask 0100, mem_wdata 0xABABABAB
   - SH 0x22, wdata 0x0000CAFE -> wmask 1100, mem_wdata 0xCAFECAFE
   - SW 0x24 -> wmask 1111
   - each store: resp_valid after edge T+1
4. LW with mem_rbusy high 4 cycles in RD_WAIT, req_valid pulsed meanwhile -> exactly one resp_valid, 4 cycles later than test 1; the extra request is not accepted.
5. resetn low during RD_WAIT -> mem_rstrb/mem_wmask/resp_valid 0 immediately; no resp_valid after release; the next LW completes normally.
6. LH at addr 0x11:
   - with LSU_MISALIGN_TRAP_EN: no mem_rstrb, resp_valid after edge T+1 with misalign_err = 1, resp_rdata 0.
   - without the macro: returns the sign-extended low half of word 0x10.
